// File: rtl/cog_run_extractor.sv
// cog_run_extractor
//   Receive stage for the centre-of-gravity chain. It takes a pixel+mask
//   AXI-Stream, finds every horizontal run of non-zero mask pixels on each
//   line, and emits one beat per run pixel. It also emits one beat for each
//   line's last pixel, whether or not that pixel is part of a run.
//   A one-entry hold register (H) provides the single pixel of lookahead
//   needed to decide whether a figure pixel closes its run.
//
// Ports
//   i_sys_clk, i_sys_areset     clock, asynchronous active-high reset
//   i_width, i_height           frame geometry (static during a frame, >= 2)
//   s_axis_*                    input stream; tdata = {mask, image}, tuser = SOF
//   m_axis_*                    output stream; tdata = image value of the beat
//   o_fig                       beat's pixel belongs to a run
//   o_run_start / o_run_end     first / last pixel of a run
//   o_run_x                     x of the run's first pixel (on o_fig beats)
//   o_run_y                     line index of the beat
//   o_run_len                   run length (on o_run_end beats)
//   o_run_short                 run ended shorter than MIN_RUN
//   o_eol / o_eof               last pixel of a line / of the frame
//   o_err_geometry              sticky tlast/tuser geometry error
module cog_run_extractor #(
  parameter int DATA_WIDTH  = 8,
  parameter int COORD_WIDTH = 11,
  parameter int MIN_RUN     = 2
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_areset,
  input  logic [COORD_WIDTH-1:0]  i_width,
  input  logic [COORD_WIDTH-1:0]  i_height,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tuser,
  output logic                    o_fig,
  output logic                    o_run_start,
  output logic                    o_run_end,
  output logic [COORD_WIDTH-1:0]  o_run_x,
  output logic [COORD_WIDTH-1:0]  o_run_y,
  output logic [COORD_WIDTH-1:0]  o_run_len,
  output logic                    o_run_short,
  output logic                    o_eol,
  output logic                    o_eof,
  output logic                    o_err_geometry
);

  localparam logic [COORD_WIDTH-1:0] C_ZERO    = {COORD_WIDTH{1'b0}};
  localparam logic [COORD_WIDTH-1:0] C_ONE     = {{(COORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COORD_WIDTH-1:0] C_MAX     = {COORD_WIDTH{1'b1}};
  localparam logic [COORD_WIDTH-1:0] C_MIN_RUN = COORD_WIDTH'(MIN_RUN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OUTSIDE = 2'd1,
    ST_IN_RUN  = 2'd2
  } state_t;

  // Run length increment that sticks at the all-ones value.
  function automatic logic [COORD_WIDTH-1:0] sat_inc(input logic [COORD_WIDTH-1:0] v);
    if (v == C_MAX) begin
      sat_inc = C_MAX;
    end else begin
      sat_inc = v + C_ONE;
    end
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;

  // Coordinates of the next beat to be counted.
  logic [COORD_WIDTH-1:0]  x_r;
  logic [COORD_WIDTH-1:0]  y_r;

  // Start x and running length of the run the most recent pixel belongs to.
  logic [COORD_WIDTH-1:0]  cur_run_x_r;
  logic [COORD_WIDTH-1:0]  cur_len_r;

  // Hold register H.
  logic                    h_valid_r;
  logic [DATA_WIDTH-1:0]   h_pix_r;
  logic                    h_fig_r;
  logic [COORD_WIDTH-1:0]  h_x_r;
  logic [COORD_WIDTH-1:0]  h_y_r;
  logic                    h_start_r;
  logic                    h_first_r;
  logic [COORD_WIDTH-1:0]  h_run_x_r;
  logic [COORD_WIDTH-1:0]  h_len_r;

  logic [COORD_WIDTH-1:0]  w_last_s;
  logic [COORD_WIDTH-1:0]  h_last_s;
  logic [DATA_WIDTH-1:0]   in_mask_s;
  logic [DATA_WIDTH-1:0]   in_pix_s;
  logic                    out_free_s;
  logic                    acc_s;
  logic                    take_s;
  logic                    restart_s;
  logic                    mid_tuser_s;
  logic [COORD_WIDTH-1:0]  cx_s;
  logic [COORD_WIDTH-1:0]  cy_s;
  logic                    in_fig_s;
  logic                    in_end_s;
  logic                    prev_in_run_s;
  logic                    in_start_s;
  logic [COORD_WIDTH-1:0]  in_run_x_s;
  logic [COORD_WIDTH-1:0]  in_len_s;
  logic                    in_first_s;
  logic                    h_end_s;
  logic                    release_s;
  logic                    emit_s;
  logic                    run_end_s;
  logic                    tlast_bad_s;

  assign w_last_s   = i_width - C_ONE;
  assign h_last_s   = i_height - C_ONE;
  assign in_pix_s   = s_axis_tdata[DATA_WIDTH-1:0];
  assign in_mask_s  = s_axis_tdata[2*DATA_WIDTH-1:DATA_WIDTH];
  assign out_free_s = ~m_axis_tvalid | m_axis_tready;

  assign s_axis_tready = ~i_sys_areset & out_free_s;
  assign acc_s         = s_axis_tvalid & s_axis_tready;

  // In IDLE only a tuser beat is counted; everything else is dropped.
  assign take_s      = acc_s & ((state_r != ST_IDLE) | s_axis_tuser);
  assign restart_s   = take_s & s_axis_tuser;
  assign mid_tuser_s = restart_s & (state_r != ST_IDLE) & ((x_r != C_ZERO) | (y_r != C_ZERO));

  assign in_fig_s    = (in_mask_s != {DATA_WIDTH{1'b0}});
  assign in_end_s    = (cx_s == w_last_s);
  assign tlast_bad_s = take_s & (s_axis_tlast != in_end_s);

  // Coordinates of the incoming beat: a tuser beat is always x=0,y=0.
  always_comb begin
    cx_s = x_r;
    cy_s = y_r;
    if (restart_s) begin
      cx_s = C_ZERO;
      cy_s = C_ZERO;
    end else begin
      cx_s = x_r;
      cy_s = y_r;
    end
  end

  // Run bookkeeping for the incoming beat.
  always_comb begin
    prev_in_run_s = 1'b0;
    case (state_r)
      ST_IN_RUN: prev_in_run_s = 1'b1;
      default:   prev_in_run_s = 1'b0;
    endcase
    in_start_s = in_fig_s & (restart_s | ~prev_in_run_s);
    in_run_x_s = cur_run_x_r;
    in_len_s   = cur_len_r;
    if (in_start_s) begin
      in_run_x_s = cx_s;
      in_len_s   = C_ONE;
    end else begin
      in_run_x_s = cur_run_x_r;
      in_len_s   = sat_inc(cur_len_r);
    end
  end

  // H release: on a new counted beat, or on its own once it holds a line end.
  assign h_end_s   = (h_x_r == w_last_s);
  assign release_s = h_valid_r & out_free_s & (take_s | h_end_s);
  assign emit_s    = release_s & ~mid_tuser_s & (h_fig_r | h_end_s);
  assign run_end_s = h_fig_r & (h_end_s | ~in_fig_s);

  // A frame-start mark that was on a discarded H pixel moves to its successor.
  assign in_first_s = restart_s | (h_valid_r & h_first_r & ~emit_s);

  // FSM state register.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: decided by each counted beat.
  always_comb begin
    state_nxt_s = state_r;
    if (take_s) begin
      if (in_end_s & (cy_s == h_last_s)) begin
        state_nxt_s = ST_IDLE;
      end else if (in_fig_s & ~in_end_s) begin
        state_nxt_s = ST_IN_RUN;
      end else begin
        state_nxt_s = ST_OUTSIDE;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // x/y counters, wrapping on i_width and i_height.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      x_r <= C_ZERO;
      y_r <= C_ZERO;
    end else if (take_s) begin
      if (in_end_s) begin
        x_r <= C_ZERO;
        y_r <= (cy_s == h_last_s) ? C_ZERO : (cy_s + C_ONE);
      end else begin
        x_r <= cx_s + C_ONE;
        y_r <= cy_s;
      end
    end
  end

  // Current run start and length, updated on every counted figure pixel.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      cur_run_x_r <= C_ZERO;
      cur_len_r   <= C_ZERO;
    end else if (take_s & in_fig_s) begin
      cur_run_x_r <= in_run_x_s;
      cur_len_r   <= in_len_s;
    end
  end

  // Hold register: loads every counted beat, empties on a flush release.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      h_valid_r <= 1'b0;
      h_pix_r   <= {DATA_WIDTH{1'b0}};
      h_fig_r   <= 1'b0;
      h_x_r     <= C_ZERO;
      h_y_r     <= C_ZERO;
      h_start_r <= 1'b0;
      h_first_r <= 1'b0;
      h_run_x_r <= C_ZERO;
      h_len_r   <= C_ZERO;
    end else if (take_s) begin
      h_valid_r <= 1'b1;
      h_pix_r   <= in_pix_s;
      h_fig_r   <= in_fig_s;
      h_x_r     <= cx_s;
      h_y_r     <= cy_s;
      h_start_r <= in_start_s;
      h_first_r <= in_first_s;
      h_run_x_r <= in_run_x_s;
      h_len_r   <= in_len_s;
    end else if (release_s) begin
      h_valid_r <= 1'b0;
    end
  end

  // Output register: loads on emit, otherwise holds until downstream takes it.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= {DATA_WIDTH{1'b0}};
      m_axis_tuser  <= 1'b0;
      o_fig         <= 1'b0;
      o_run_start   <= 1'b0;
      o_run_end     <= 1'b0;
      o_run_x       <= C_ZERO;
      o_run_y       <= C_ZERO;
      o_run_len     <= C_ZERO;
      o_run_short   <= 1'b0;
      o_eol         <= 1'b0;
      o_eof         <= 1'b0;
    end else if (emit_s) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= h_pix_r;
      m_axis_tuser  <= h_first_r;
      o_fig         <= h_fig_r;
      o_run_start   <= h_start_r;
      o_run_end     <= run_end_s;
      o_run_x       <= h_fig_r ? h_run_x_r : C_ZERO;
      o_run_y       <= h_y_r;
      o_run_len     <= h_fig_r ? h_len_r : C_ZERO;
      o_run_short   <= run_end_s & (h_len_r < C_MIN_RUN);
      o_eol         <= h_end_s;
      o_eof         <= h_end_s & (h_y_r == h_last_s);
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Sticky geometry error; a clean frame start clears it unless that beat is bad too.
  always_ff @(posedge i_sys_clk or posedge i_sys_areset) begin
    if (i_sys_areset) begin
      o_err_geometry <= 1'b0;
    end else if (mid_tuser_s | tlast_bad_s) begin
      o_err_geometry <= 1'b1;
    end else if (restart_s) begin
      o_err_geometry <= 1'b0;
    end
  end

endmodule
